// File: rtl/regfile_wb_pkg.sv
// Shared processor constants for the architectural register file and the
// write stage that targets $rstatus / $ra directly.
package regfile_wb_pkg;

   // Default datapath geometry of the processor.
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   // Architectural register indices with fixed meaning.
   localparam int REG_ZERO   = 0;
   localparam int REG_STATUS = 30;
   localparam int REG_LINK   = 31;

   // Index type at the default geometry, used by the write stage.
   typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

   // Named indices as the write stage sees them (5'd30 / 5'd31 targets).
   localparam reg_idx_t IDX_ZERO   = reg_idx_t'(REG_ZERO);
   localparam reg_idx_t IDX_STATUS = reg_idx_t'(REG_STATUS);
   localparam reg_idx_t IDX_LINK   = reg_idx_t'(REG_LINK);

endpackage

// File: rtl/regfile_wb_read_port.sv
// One read port of the register file: array lookup with optional forwarding
// of the write presented in the same cycle. Index 0 always reads as zero.
module regfile_read_port
   import regfile_wb_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_wb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_wb_pkg::ADDR_WIDTH,
   parameter int BYPASS_EN  = 1
) (
   input  logic [ADDR_WIDTH-1:0]                        idx,
   input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   regs,
   input  logic                                         wr_en,
   input  logic [ADDR_WIDTH-1:0]                        wr_idx,
   input  logic [DATA_WIDTH-1:0]                        wr_data,
   output logic [DATA_WIDTH-1:0]                        data
);

   logic hit;

   // Forwarding applies only to a live write to the same nonzero index.
   always_comb begin
      hit  = 1'b0;
      data = regs[idx];
      if ((BYPASS_EN != 0) && wr_en && (wr_idx == idx) && (idx != '0)) begin
         hit = 1'b1;
      end
      if (hit) begin
         data = wr_data;
      end
      if (idx == '0) begin
         data = '0;
      end
   end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file fed by the writeback port. Two combinational
// decode read ports, a one-cycle registered debug read port, a live copy of
// $rstatus and a sticky exception flag raised by nonzero $rstatus writes.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_wb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_wb_pkg::ADDR_WIDTH,
   parameter int STATUS_REG = REG_STATUS,
   parameter int BYPASS_EN  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0] data_writeReg,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
   output logic [DATA_WIDTH-1:0] data_readRegA,
   output logic [DATA_WIDTH-1:0] data_readRegB,
   input  logic                  dbg_req,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic                  dbg_valid,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic [DATA_WIDTH-1:0] rstatus,
   output logic                  exc_pending,
   input  logic                  exc_ack
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(STATUS_REG);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
   logic                                wr_fire;
   logic                                exc_set;
   logic [DATA_WIDTH-1:0]               dbg_next;

   // A write lands only when enabled, not to reg 0, and outside reset.
   always_comb begin
      wr_fire = ctrl_writeEnable && (ctrl_writeReg != '0) && !reset;
      exc_set = wr_fire && (ctrl_writeReg == STATUS_IDX) && (data_writeReg != '0);
   end

   // Register array; reset clears every entry, reg 0 is never written.
   always_ff @(posedge clock) begin
      if (reset) begin
         regs <= '0;
      end else if (wr_fire) begin
         regs[ctrl_writeReg] <= data_writeReg;
      end
   end

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS_EN  (BYPASS_EN)
   ) u_port_a (
      .idx     (ctrl_readRegA),
      .regs    (regs),
      .wr_en   (ctrl_writeEnable),
      .wr_idx  (ctrl_writeReg),
      .wr_data (data_writeReg),
      .data    (data_readRegA)
   );

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS_EN  (BYPASS_EN)
   ) u_port_b (
      .idx     (ctrl_readRegB),
      .regs    (regs),
      .wr_en   (ctrl_writeEnable),
      .wr_idx  (ctrl_writeReg),
      .wr_data (data_writeReg),
      .data    (data_readRegB)
   );

   // The debug port always forwards: it returns the value after this edge's write.
   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS_EN  (1)
   ) u_port_dbg (
      .idx     (dbg_addr),
      .regs    (regs),
      .wr_en   (ctrl_writeEnable),
      .wr_idx  (ctrl_writeReg),
      .wr_data (data_writeReg),
      .data    (dbg_next)
   );

   // Debug response register: one valid pulse per request, data held otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         dbg_valid <= 1'b0;
         dbg_data  <= '0;
      end else begin
         dbg_valid <= dbg_req;
         if (dbg_req) begin
            dbg_data <= dbg_next;
         end
      end
   end

   // Sticky exception flag; a set on the same edge overrides the ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         exc_pending <= 1'b0;
      end else if (exc_set) begin
         exc_pending <= 1'b1;
      end else if (exc_ack) begin
         exc_pending <= 1'b0;
      end
   end

   // $rstatus is exposed straight from the array, without forwarding.
   always_comb begin
      rstatus = regs[STATUS_IDX];
   end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vectors, debug responses checked through an
// expected-value queue drained by a monitor on dbg_valid.
module tb_regfile_wb;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_readRegA, data_readRegB;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic        dbg_valid;
   logic [31:0] dbg_data;
   logic [31:0] rstatus;
   logic        exc_pending;
   logic        exc_ack;

   logic [31:0] nb_readRegA, nb_readRegB, nb_dbg_data, nb_rstatus;
   logic        nb_dbg_valid, nb_exc_pending;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   regfile_wb #(.BYPASS_EN(1)) dut (
      .clock(clock), .reset(reset),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr),
      .dbg_valid(dbg_valid), .dbg_data(dbg_data),
      .rstatus(rstatus), .exc_pending(exc_pending), .exc_ack(exc_ack)
   );

   regfile_wb #(.BYPASS_EN(0)) dut_nb (
      .clock(clock), .reset(reset),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(nb_readRegA), .data_readRegB(nb_readRegB),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr),
      .dbg_valid(nb_dbg_valid), .dbg_data(nb_dbg_data),
      .rstatus(nb_rstatus), .exc_pending(nb_exc_pending), .exc_ack(exc_ack)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every debug response is matched against the next expected value.
   always @(negedge clock) begin
      if (dbg_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL dbg_unexpected: got valid data 0x%08h want no response", dbg_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (dbg_data !== e) begin
               bad++;
               $display("FAIL dbg_data: got 0x%08h want 0x%08h", dbg_data, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg = '0;
      data_writeReg = '0;
      ctrl_readRegA = '0;
      ctrl_readRegB = '0;
      dbg_req = 1'b0;
      dbg_addr = '0;
      exc_ack = 1'b0;
      tick();
      reset = 1'b0;

      // 1. post-reset state
      for (int i = 0; i < 32; i++) begin
         ctrl_readRegA = 5'(i);
         ctrl_readRegB = 5'(31 - i);
         #1;
         chk($sformatf("rst_a%0d", i), data_readRegA, 32'h0);
         chk($sformatf("rst_b%0d", 31 - i), data_readRegB, 32'h0);
      end
      chk("rst_rstatus", rstatus, 32'h0);
      chk("rst_exc", {31'h0, exc_pending}, 32'h0);
      chk("rst_dbg_valid", {31'h0, dbg_valid}, 32'h0);

      // 2. same-cycle bypass vs. no bypass
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd5;
      data_writeReg = 32'hDEADBEEF;
      ctrl_readRegA = 5'd5;
      #1;
      chk("byp_a_same", data_readRegA, 32'hDEADBEEF);
      chk("nobyp_a_same", nb_readRegA, 32'h0);
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      chk("byp_a_after", data_readRegA, 32'hDEADBEEF);
      chk("nobyp_a_after", nb_readRegA, 32'hDEADBEEF);

      // 3. reg 0 is hardwired zero
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd0;
      data_writeReg = 32'h1234;
      ctrl_readRegB = 5'd0;
      #1;
      chk("r0_b_same", data_readRegB, 32'h0);
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      chk("r0_b_after", data_readRegB, 32'h0);
      tick();
      chk("r0_b_later", data_readRegB, 32'h0);

      // 4. $rstatus and exception flag
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd30;
      data_writeReg = 32'h1;
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      chk("st1_rstatus", rstatus, 32'h1);
      chk("st1_exc", {31'h0, exc_pending}, 32'h1);
      ctrl_writeEnable = 1'b1;
      data_writeReg = 32'h2;
      exc_ack = 1'b1;
      tick();
      ctrl_writeEnable = 1'b0;
      exc_ack = 1'b0;
      #1;
      chk("st2_rstatus", rstatus, 32'h2);
      chk("st2_exc_set_wins", {31'h0, exc_pending}, 32'h1);
      exc_ack = 1'b1;
      tick();
      exc_ack = 1'b0;
      #1;
      chk("st3_exc_acked", {31'h0, exc_pending}, 32'h0);
      ctrl_writeEnable = 1'b1;
      data_writeReg = 32'h0;
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      chk("st4_rstatus", rstatus, 32'h0);
      chk("st4_exc", {31'h0, exc_pending}, 32'h0);

      // 5. back-to-back debug reads
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd8;
      data_writeReg = 32'hA5A5_0008;
      tick();
      ctrl_writeReg = 5'd7;
      data_writeReg = 32'h55;
      dbg_req = 1'b1;
      dbg_addr = 5'd7;
      exp_q.push_back(32'h55);
      tick();
      ctrl_writeEnable = 1'b0;
      dbg_addr = 5'd8;
      exp_q.push_back(32'hA5A5_0008);
      tick();
      dbg_addr = 5'd7;
      exp_q.push_back(32'h55);
      tick();
      dbg_req = 1'b0;
      tick();
      chk("dbg_idle_valid", {31'h0, dbg_valid}, 32'h0);
      chk("dbg_idle_hold", dbg_data, 32'h55);

      // 6. reset wins over write and debug request
      reset = 1'b1;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd9;
      data_writeReg = 32'hFF;
      dbg_req = 1'b1;
      dbg_addr = 5'd9;
      tick();
      reset = 1'b0;
      ctrl_writeEnable = 1'b0;
      dbg_req = 1'b0;
      ctrl_readRegA = 5'd9;
      ctrl_readRegB = 5'd5;
      #1;
      chk("rst2_dbg_valid", {31'h0, dbg_valid}, 32'h0);
      chk("rst2_dbg_data", dbg_data, 32'h0);
      chk("rst2_r9", data_readRegA, 32'h0);
      chk("rst2_r5", data_readRegB, 32'h0);

      repeat (3) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL dbg_missing: got %0d responses outstanding want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
